sum_every_n: RTL

- Parametrised successor of the fixed sum-every-3 streaming DUT.
- Accumulates a valid-qualified input stream and emits one sum per group of N samples.
- N is selected at run time, up to MAX_N.
- Supports signed or unsigned data, an explicit flush that emits partial groups, and reports the sample count of every emitted group.
- Sits between a valid-only producer and a valid-only consumer. There is no backpressure.

---
 rtl/sum_every_n_pkg.sv | 26 ++
 rtl/sen_group_ctrl.sv | 102 ++++++++++
 rtl/sum_every_n.sv | 85 ++++++++
 3 files changed

// File: rtl/sum_every_n_pkg.sv
// Shared types and helpers for the sum_every_n streaming group accumulator.
//   sen_state_t : group controller state (IDLE = no open group, ACC = group open)
//   clamp_n     : maps a requested group size onto 1..max_n
//   sen_ow      : output sum width that cannot overflow for a full group
package sum_every_n_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } sen_state_t;

  // 0 is treated as 1 and anything above max_n saturates to max_n.
  function automatic int unsigned clamp_n(input int unsigned n, input int unsigned max_n);
    if (n == 0)
      return 1;
    else if (n > max_n)
      return max_n;
    else
      return n;
  endfunction

  function automatic int unsigned sen_ow(input int unsigned iw, input int unsigned max_n);
    return iw + $clog2(max_n);
  endfunction

endpackage

// File: rtl/sen_group_ctrl.sv
// Group controller for sum_every_n: tracks samples in the open group, latches
// the effective group size at the first sample, and decodes completion/flush.
//   clk, rst       : clock, asynchronous active-low reset
//   i_n            : requested group size (used only at the first sample)
//   i_dval         : input sample valid
//   i_flush        : close the open group early
//   acc_load       : accumulator starts a new group with this sample
//   acc_add        : accumulator adds this sample to the open group
//   emit           : a group closes this cycle (sum includes this cycle's sample)
//   partial        : closing group holds fewer samples than its group size
//   emit_cnt       : sample count of the closing group
module sen_group_ctrl
  import sum_every_n_pkg::*;
#(
  parameter int unsigned MAX_N = 8,
  parameter int unsigned CW    = $clog2(MAX_N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] i_n,
  input  logic          i_dval,
  input  logic          i_flush,
  output logic          acc_load,
  output logic          acc_add,
  output logic          emit,
  output logic          partial,
  output logic [CW-1:0] emit_cnt
);

  sen_state_t    state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [CW-1:0] n_eff, n_eff_nxt;
  logic [CW-1:0] n_sel;
  logic [CW-1:0] cnt_inc;

  assign n_sel   = CW'(clamp_n(32'(i_n), MAX_N));
  assign cnt_inc = count + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
      n_eff <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      n_eff <= n_eff_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    n_eff_nxt = n_eff;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    emit      = 1'b0;
    partial   = 1'b0;
    emit_cnt  = count;
    case (state)
      ST_IDLE: begin
        if (i_dval) begin
          acc_load  = 1'b1;
          n_eff_nxt = n_sel;
          emit_cnt  = CW'(1);
          // A one-sample group (n_eff==1 or flushed immediately) never enters ACC.
          if (n_sel == CW'(1) || i_flush) begin
            emit    = 1'b1;
            partial = (n_sel != CW'(1));
          end else begin
            state_nxt = ST_ACC;
            count_nxt = CW'(1);
          end
        end
      end
      ST_ACC: begin
        if (i_dval) begin
          acc_add  = 1'b1;
          emit_cnt = cnt_inc;
          if (cnt_inc == n_eff || i_flush) begin
            emit      = 1'b1;
            partial   = (cnt_inc < n_eff);
            state_nxt = ST_IDLE;
            count_nxt = '0;
          end else begin
            count_nxt = cnt_inc;
          end
        end else if (i_flush) begin
          emit      = 1'b1;
          partial   = 1'b1;
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/sum_every_n.sv
// Streaming accumulator emitting one sum per group of a run-time selectable
// number of samples (1..MAX_N), with early flush and per-group sample count.
//   clk, rst   : clock, asynchronous active-low reset
//   i_n        : requested group size, sampled at the first sample of a group
//   i_dval, i  : input sample valid / sample
//   i_flush    : close the open group early
//   o_dval     : one-cycle pulse, group result valid
//   o          : group sum (sign- or zero-extended per SIGNED)
//   o_cnt      : samples in the emitted group
//   o_partial  : group was closed by flush before reaching its size
module sum_every_n
  import sum_every_n_pkg::*;
#(
  parameter int unsigned IW     = 8,
  parameter int unsigned MAX_N  = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned CW     = $clog2(MAX_N + 1),
  parameter int unsigned OW     = sen_ow(IW, MAX_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] i_n,
  input  logic          i_dval,
  input  logic [IW-1:0] i,
  input  logic          i_flush,
  output logic          o_dval,
  output logic [OW-1:0] o,
  output logic [CW-1:0] o_cnt,
  output logic          o_partial
);

  logic          acc_load, acc_add, emit, partial;
  logic [CW-1:0] emit_cnt;
  logic [OW-1:0] ext_i;
  logic [OW-1:0] acc, acc_nxt;

  sen_group_ctrl #(
    .MAX_N (MAX_N),
    .CW    (CW)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_n      (i_n),
    .i_dval   (i_dval),
    .i_flush  (i_flush),
    .acc_load (acc_load),
    .acc_add  (acc_add),
    .emit     (emit),
    .partial  (partial),
    .emit_cnt (emit_cnt)
  );

  always_comb begin
    ext_i = (SIGNED != 0) ? OW'($signed(i)) : OW'(i);
  end

  // acc_nxt already includes this cycle's sample, so the emitted sum is taken
  // from it directly rather than from acc a cycle later.
  always_comb begin
    acc_nxt = acc;
    if (acc_load)
      acc_nxt = ext_i;
    else if (acc_add)
      acc_nxt = acc + ext_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      o_dval    <= 1'b0;
      o         <= '0;
      o_cnt     <= '0;
      o_partial <= 1'b0;
    end else begin
      acc    <= acc_nxt;
      o_dval <= emit;
      if (emit) begin
        o         <= acc_nxt;
        o_cnt     <= emit_cnt;
        o_partial <= partial;
      end
    end
  end

endmodule
